// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage RV32M multiply/divide unit.
// Holds the RV32M funct3 encodings, the iteration count and the FSM state type.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring
// divide sharing one accumulator and one sign-fix negator; stalls the front end.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 kill,
  input  logic [2:0]           md_op,
  input  logic [WORD_SIZE-1:0] op_a,
  input  logic [WORD_SIZE-1:0] op_b,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result
);

  localparam int W = WORD_SIZE;

  md_state_e          state, state_nx;
  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q;
  logic [W-1:0]       mag_b_q;
  logic [2*W-1:0]     acc_q;
  logic [4:0]         cnt_q;

  logic               accept, last_iter;
  logic               a_signed, b_signed, in_sign_a, in_sign_b;
  logic [W-1:0]       in_mag_a, in_mag_b;
  logic               div_zero, div_ovf, fast;
  logic [W-1:0]       fast_res;

  logic [W:0]         mul_sum;
  logic [W:0]         rem_sh;
  logic [W-1:0]       div_diff;
  logic               div_ok;
  logic [2*W-1:0]     acc_nx;
  logic [2*W-1:0]     fix_in, fixed;
  logic               fix_neg;
  logic [W-1:0]       result_nx;

  function automatic logic [2*W-1:0] neg_fix(input logic [2*W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  assign accept    = (state == ST_IDLE) && start && !kill;
  assign last_iter = (cnt_q == 5'(MD_ITER - 1));

  // Operand decode in IDLE: signedness, magnitudes and the divide fast path
  always_comb begin
    a_signed  = (md_op != MD_MULHU) && (md_op != MD_DIVU) && (md_op != MD_REMU);
    b_signed  = (md_op == MD_MUL) || (md_op == MD_MULH) ||
                (md_op == MD_DIV) || (md_op == MD_REM);
    in_sign_a = a_signed && op_a[W-1];
    in_sign_b = b_signed && op_b[W-1];
    in_mag_a  = in_sign_a ? (~op_a + 1'b1) : op_a;
    in_mag_b  = in_sign_b ? (~op_b + 1'b1) : op_b;
    div_zero  = md_is_div(md_op) && (op_b == '0);
    div_ovf   = ((md_op == MD_DIV) || (md_op == MD_REM)) &&
                (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    fast      = div_zero || div_ovf;
    fast_res  = '0;
    if (div_zero)
      fast_res = md_op[1] ? op_a : '1;
    else if (div_ovf)
      fast_res = md_op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // One iteration: multiply adds into the high half and shifts right;
  // divide shifts the remainder left and subtracts when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    rem_sh   = acc_q[2*W-1:W-1];
    div_ok   = (rem_sh >= {1'b0, mag_b_q});
    div_diff = rem_sh[W-1:0] - mag_b_q;
    if (md_is_div(op_q))
      acc_nx = div_ok ? {div_diff, acc_q[W-2:0], 1'b1}
                      : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    else
      acc_nx = {mul_sum, acc_q[W-1:1]};

    if (!md_is_div(op_q)) begin
      fix_in  = acc_nx;
      fix_neg = sign_a_q ^ sign_b_q;
    end else if (op_q[1]) begin
      fix_in  = {{W{1'b0}}, acc_nx[2*W-1:W]};
      fix_neg = sign_a_q;
    end else begin
      fix_in  = {{W{1'b0}}, acc_nx[W-1:0]};
      fix_neg = sign_a_q ^ sign_b_q;
    end
    fixed = neg_fix(fix_in, fix_neg);

    if (md_is_div(op_q) || (op_q == MD_MUL))
      result_nx = fixed[W-1:0];
    else
      result_nx = fixed[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (kill) state_nx = ST_IDLE;
  end

  assign stall = !rst && (accept || (state == ST_CALC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      busy <= (state_nx == ST_CALC);
      done <= (state_nx == ST_DONE);
      if (accept) begin
        op_q     <= md_op;
        sign_a_q <= in_sign_a;
        sign_b_q <= in_sign_b;
        mag_b_q  <= in_mag_b;
        acc_q    <= {{W{1'b0}}, in_mag_a};
        cnt_q    <= '0;
        if (fast) result <= fast_res;
      end else if ((state == ST_CALC) && !kill) begin
        acc_q <= acc_nx;
        cnt_q <= cnt_q + 5'd1;
        if (last_iter) result <= result_nx;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: stimulus pushes expected results into a
// scoreboard queue; a monitor pops and compares on every done pulse.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  md_op;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  done_cnt = 0;

  ex_muldiv #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .md_op(md_op),
    .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got result 0x%08h expected no done", result);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk(e.name, result, e.exp);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    int stalls;
    bit seen;
    sb_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    cyc = 0; stalls = 0; seen = 0;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
        op_a = ~a; op_b = ~b;
      end
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'(cyc), 32'(lat));
      start = 1'b0;
      return;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(lat));
    chk({name, "_stalls"}, 32'(stalls), 32'(lat));
    // start still high across the DONE edge: must not restart
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_no_restart"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    int          dc;
    rst = 1'b1; start = 1'b1; kill = 1'b0; md_op = MD_MUL; op_a = 32'd3; op_b = 32'd4;
    #12;
    chk("reset_outputs", {29'd0, stall, busy, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mul_7x-3",      MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_min_m1",   MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu_min_m1", MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("mulhu_min_m1",  MD_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);
    run_op("mul_shift",     MD_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    run_op("div_-7_2",      MD_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    run_op("rem_-7_2",      MD_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    run_op("divu_max_16",   MD_DIVU,   32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, 33);
    run_op("remu_100_7",    MD_REMU,   32'd100,      32'd7,        32'd2,         33);
    run_op("div_5_0",       MD_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("rem_5_0",       MD_REM,    32'd5,        32'd0,        32'd5,         1);
    run_op("divu_5_0",      MD_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("div_ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // kill at cycle 10 of a DIV
    prev = result;
    dc   = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_DIV; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("kill_idle", {30'd0, stall, busy}, 32'd0);
    chk("kill_result_held", result, prev);
    repeat (40) @(negedge clk);
    chk("kill_no_done", 32'(done_cnt), 32'(dc));

    // kill together with start in IDLE
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; md_op = MD_MUL; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    chk("kill_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_start_idle", {30'd0, busy, done}, 32'd0);
    chk("kill_start_result", result, prev);

    // reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULHU; op_a = 32'd9; op_b = 32'd9;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {29'd0, stall, busy, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("mulhu_max_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes forwarded operands and an M-extension opcode, runs a 32-iteration shift-add multiply or restoring divide, and raises a combinational stall that holds ID/EX and earlier stages until the result is ready. The result feeds the EX result mux alongside the ALU output.

## Interface
- `WORD_SIZE`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: the instruction in EX is an M-extension op; level signal, held while ID/EX is stalled.
- `kill`  in  1: synchronous flush of the EX instruction (branch/jump redirect).
- `md_op`  in  3: RV32M funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  WORD_SIZE: rs1 value after forwarding.
- `op_b`  in  WORD_SIZE: rs2 value after forwarding.
- `stall`  out  1: combinational; drives the ID/EX and IF/ID stall inputs.
- `busy`  out  1: registered; high while in CALC.
- `done`  out  1: registered; one-cycle pulse when `result` is valid.
- `result`  out  WORD_SIZE: registered result, held until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, with `start` & !`kill`:
  - Latch `md_op`, the operand magnitudes, and the operand signs.
  - Clear the 5-bit iteration counter.
  - Go to CALC.
  - Fast path: divide by zero, or signed overflow (DIV/REM with `op_a`=0x80000000, `op_b`=0xFFFFFFFF). Load the special result and go directly to DONE.
- CALC: one iteration per cycle, counter 0..31. At counter 31, apply sign correction, write `result`, and go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored in DONE, because it is the same stalled instruction that has just completed.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Multiply:
  - Unsigned 32x32 to 64-bit product of the magnitudes.
  - Negate the 64-bit product if sign_a^sign_b.
  - MUL returns bits [31:0]; the other multiply ops return bits [63:32].
- Divide:
  - Restoring division on the magnitudes, using a 33-bit partial remainder.
  - Quotient is negated if sign_a^sign_b; remainder is negated if sign_a.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder `op_a`.
  - Signed overflow: quotient 0x80000000, remainder 0.
- `stall` = (IDLE & `start` & !`kill`) | CALC. It is 0 in DONE, so the pipeline advances and the result is captured into EX/MEM that cycle.
- `kill` in any state: go to IDLE at the next edge. `done` is not pulsed and `result` is unchanged. `kill` wins over `start` in the same cycle.
- Reset values: state IDLE, counter 0, `busy` 0, `done` 0, `result` 0, all latched operands 0. `stall` is 0 while `rst` is high.

## Timing
- Normal op, `start` first seen in IDLE at cycle 0:
  - CALC in cycles 1..32.
  - DONE in cycle 33: `done`=1 and `result` valid.
  - `stall` is high in cycles 0..32, i.e. 33 stall cycles.
- Fast path: `stall` high in cycle 0 only; DONE and `done` in cycle 1.
- Back-to-back M ops: the second instruction reaches EX in cycle 34 (IDLE) and starts normally. No bubble is needed beyond the DONE cycle.
- Operands are sampled only in IDLE. Forwarding changes during CALC are ignored.
- `rst` mid-operation: immediate return to IDLE with the reset values listed above.

## Structure
- Add the `MD_*` funct3 constants and the `MD_ITER`=32 constant to the shared `defines.vh`.
- State encodings are local parameters.
- Single module. The multiply and divide share the counter, the 64-bit accumulator/remainder register and the sign-fix negator. No sub-module is required.

## Test plan
- MUL 7 x -3: `stall` high for 33 cycles; `done` at cycle 33 with `result`=0xFFFFFFEB.
- MULH, MULHSU, MULHU with 0x80000000 x 0xFFFFFFFF: results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2: `result`=0xFFFFFFFD. REM -7/2: `result`=0xFFFFFFFF. DIVU 0xFFFFFFFF/16: `result`=0x0FFFFFFF.
- DIV 5/0: fast path, `done` at cycle 1, `result`=0xFFFFFFFF. REM 5/0: `result`=5. DIV 0x80000000/-1: `result`=0x80000000, and REM of the same operands gives 0.
- `kill` asserted at cycle 10 of a DIV: IDLE at cycle 11, `stall` low, no `done`, `result` keeps its previous value. `kill` together with `start` in IDLE: no stall and no state change.
- Reset asserted mid-CALC: outputs go to their reset values immediately. After release, a new MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE. `start` held high during DONE does not restart the unit.
